// File: rtl/ram_reader.sv
// ram_reader: sweeps an address window of a registered-read RAM and streams
// each word out on a valid/ready interface. A read whose ISSUE cycle
// coincided with a RAM write returns the write data (write-first), so it is
// discarded and the same address is read again.
module ram_reader #(
    parameter int data_width = 8,
    parameter int ram_size   = 32,
    parameter int addr_width = $clog2(ram_size)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base,
    input  logic [addr_width:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] raddr,
    input  logic [data_width-1:0] rdata,
    input  logic                  ram_we,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(ram_size - 1);
    localparam logic [addr_width:0]   ONE_LEFT  = (addr_width + 1)'(1);

    state_t                state;
    logic [addr_width-1:0] addr_cur;
    logic [addr_width:0]   remaining;
    logic                  hit;

    // Next address in the sweep; wraps at ram_size, which need not be 2**n.
    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
        if (a == LAST_ADDR)
            return '0;
        else
            return a + 1'b1;
    endfunction

    // Transfer FSM; every output is a register driven from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            raddr     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            hit       <= 1'b0;
            addr_cur  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (count != '0) begin
                            addr_cur  <= base;
                            remaining <= count;
                            raddr     <= base;
                            busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            // Empty transfer: report completion, emit nothing.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A write during the read cycle means dout will carry din.
                    hit   <= ram_we;
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    if (hit) begin
                        state <= S_ISSUE;
                    end else begin
                        m_data  <= rdata;
                        m_last  <= (remaining == ONE_LEFT);
                        m_valid <= 1'b1;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (m_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            addr_cur <= next_addr(addr_cur);
                            raddr    <= next_addr(addr_cur);
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a write-first RAM model, a handshake monitor, directed
// cycle-exact sequences, then randomized transfers with random back-pressure
// and random RAM writes, all checked against a reference built from the
// RAM contents (mem[a] = a + 0x10) and the window rule (base + i) mod 32.
module tb_ram_reader;

    localparam int DW = 8;
    localparam int RS = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    logic          mem_init;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic [DW-1:0] mem [RS];

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] hs_data[$];
    logic          hs_last[$];
    int            done_cnt = 0;

    ram_reader #(.data_width(DW), .ram_size(RS)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
        .ram_we(ram_we), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Write-first RAM with registered read port.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < RS; i++) mem[i] <= DW'(i + 16);
        end else if (ram_we) begin
            mem[waddr] <= din;
            rdata      <= din;
        end else begin
            rdata <= mem[raddr];
        end
    end

    // Record every accepted word and every done pulse.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            hs_data.push_back(m_data);
            hs_last.push_back(m_last);
        end
        if (done) done_cnt++;
    end

    function automatic logic [DW-1:0] ref_word(input int a);
        return DW'((a % RS) + 16);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the words accepted since index 'first' with the expected window.
    task automatic check_stream(input string tag, input int b, input int c, input int first);
        check({tag, "_nwords"}, 32'(hs_data.size() - first), 32'(c));
        for (int i = 0; i < c && first + i < hs_data.size(); i++) begin
            check({tag, "_data"}, 32'(hs_data[first + i]), 32'(ref_word(b + i)));
            check({tag, "_last"}, 32'(hs_last[first + i]), 32'(i == c - 1));
        end
    endtask

    task automatic pulse_start(input int b, input int c);
        start = 1'b1;
        base  = AW'(b);
        count = (AW + 1)'(c);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // Cycle-exact transfer with m_ready high and no RAM writes (count > 0).
    task automatic run_timed(input string tag, input int b, input int c);
        int first = hs_data.size();
        pulse_start(b, c);
        for (int i = 0; i < c; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_raddr"}, 32'(raddr), 32'((b + i) % RS));
            check({tag, "_vld_issue"}, 32'(m_valid), 32'd0);
            step();
            step();
            check({tag, "_vld_send"}, 32'(m_valid), 32'd1);
            check({tag, "_mdata"}, 32'(m_data), 32'(ref_word(b + i)));
            check({tag, "_mlast"}, 32'(m_last), 32'(i == c - 1));
            step();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_vld_done"}, 32'(m_valid), 32'd0);
        step();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check_stream(tag, b, c, first);
    endtask

    initial begin
        int first;
        int done0;
        int b;
        int c;
        int n;

        rst = 1'b1; mem_init = 1'b1; start = 1'b0; base = '0; count = '0;
        ram_we = 1'b0; waddr = '0; din = '0; m_ready = 1'b1;
        step(); step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mdata", 32'(m_data), 32'd0);
        check("rst_mlast", 32'(m_last), 32'd0);
        rst = 1'b0; mem_init = 1'b0;
        step();

        // Basic window and wrap-around window.
        run_timed("basic", 4, 3);
        run_timed("wrap", 30, 4);

        // RAM write during the first ISSUE: read is discarded and re-issued.
        first = hs_data.size();
        pulse_start(2, 2);
        ram_we = 1'b1; waddr = AW'(25); din = 8'hAA;
        step();
        ram_we = 1'b0;
        check("hit_capt_vld", 32'(m_valid), 32'd0);
        step();
        check("hit_reissue_raddr", 32'(raddr), 32'd2);
        check("hit_reissue_vld", 32'(m_valid), 32'd0);
        step();
        check("hit_capt2_vld", 32'(m_valid), 32'd0);
        step();
        check("hit_send_vld", 32'(m_valid), 32'd1);
        check("hit_send_data", 32'(m_data), 32'h12);
        step();
        check("hit_w1_raddr", 32'(raddr), 32'd3);
        step(); step();
        check("hit_w1_data", 32'(m_data), 32'h13);
        check("hit_w1_last", 32'(m_last), 32'd1);
        step();
        check("hit_done", 32'(done), 32'd1);
        ram_we = 1'b1; waddr = AW'(25); din = ref_word(25);
        step();
        ram_we = 1'b0;
        check_stream("hit", 2, 2, first);

        // Back-pressure for 5 cycles on the first word; start pulse while busy.
        first = hs_data.size();
        done0 = done_cnt;
        m_ready = 1'b0;
        pulse_start(4, 3);
        step(); step();
        for (int k = 0; k < 5; k++) begin
            check("bp_vld", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'h14);
            start = (k == 2); base = '0; count = (AW + 1)'(1);
            step();
        end
        start = 1'b0;
        m_ready = 1'b1;
        wait_done("bp", 100);
        step(); step();
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_one_done", 32'(done_cnt - done0), 32'd1);
        check_stream("bp", 4, 3, first);

        // Empty transfer; a start in the DONE cycle is ignored.
        first = hs_data.size();
        pulse_start(7, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_vld", 32'(m_valid), 32'd0);
        start = 1'b1; base = AW'(3); count = (AW + 1)'(2);
        step();
        start = 1'b0;
        check("zero_done_clr", 32'(done), 32'd0);
        check("zero_ign_busy", 32'(busy), 32'd0);
        step();
        check("zero_ign_busy2", 32'(busy), 32'd0);
        check("zero_nwords", 32'(hs_data.size() - first), 32'd0);

        // Reset in CAPT of the second word, then a fresh single-word transfer.
        pulse_start(4, 3);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_raddr", 32'(raddr), 32'd0);
        check("mrst_vld", 32'(m_valid), 32'd0);
        check("mrst_mdata", 32'(m_data), 32'd0);
        check("mrst_mlast", 32'(m_last), 32'd0);
        rst = 1'b0;
        step();
        check("mrst_done2", 32'(done), 32'd0);
        check("mrst_busy2", 32'(busy), 32'd0);
        run_timed("fresh", 0, 1);

        // Randomized transfers with back-pressure, RAM writes and stray starts.
        for (int t = 0; t < 25; t++) begin
            b = int'($urandom_range(0, RS - 1));
            c = int'($urandom_range(0, 40));
            first = hs_data.size();
            pulse_start(b, c);
            n = 0;
            while (!done && n < 2000) begin
                m_ready = 1'($urandom % 2);
                ram_we  = ($urandom % 3) == 0;
                waddr   = AW'((int'(raddr) + 1 + int'($urandom_range(0, RS - 2))) % RS);
                din     = ref_word(int'(waddr));
                start   = ($urandom % 4) == 0;
                base    = AW'($urandom);
                count   = (AW + 1)'($urandom);
                step();
                n++;
            end
            check("rnd_done_seen", 32'(done), 32'd1);
            start = 1'b0; ram_we = 1'b0; m_ready = 1'b1;
            step();
            check("rnd_idle_busy", 32'(busy), 32'd0);
            check_stream("rnd", b, c, first);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
